// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
// Optional perf counters are enabled by defining PIPE_SEQ_PERF_CNT_EN.
package pipe_ctrl_pkg;

    // Sequencer states: normal flow, memory wait, fatal timeout.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        ERROR    = 2'd2
    } seq_state_t;

    // x0 is hard-wired zero, so it never creates a true dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default width of the stall/flush performance counters.
    localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Kept standalone so a future
// forwarding unit can reuse the same register comparison.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       load_use
);

    // Hazard only when a load writes a real register that ID consumes.
    always_comb begin
        load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use stalls,
// ID-stage flushes and data-memory waits with a fatal timeout.
// Define PIPE_SEQ_PERF_CNT_EN to build the stall/flush counters; otherwise
// the counter ports read as zero and no counter flops exist.
module pipeline_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             id_flush,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              TIMER_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(MEM_TIMEOUT);

    seq_state_t         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               lu;
    logic               ms;

    hazard_detect u_hazard_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .load_use    (lu)
    );

    assign ms = mem_access && !mem_ready;

    // State and wait-timer registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= RUN;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state, timer update and combinational pipeline controls.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;
        mem_timeout  = 1'b0;
        case (state_q)
            RUN, WAIT_MEM: begin
                if (timer_q == TIMER_MAX) begin
                    // Timeout already reached: freeze and report from this cycle.
                    state_d     = ERROR;
                    pipe_hold   = 1'b1;
                    mem_timeout = 1'b1;
                end else if (ms) begin
                    // Full freeze while the data memory is busy.
                    state_d   = WAIT_MEM;
                    timer_d   = timer_q + 1'b1;
                    pipe_hold = 1'b1;
                end else begin
                    // Memory idle or just completed: normal RUN priorities.
                    state_d = RUN;
                    timer_d = '0;
                    if (lu) begin
                        // Branch operands are stale under load-use, so the
                        // flush request waits for the next cycle.
                        id_ex_bubble = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        if_id_flush = id_flush;
                    end
                end
            end
            ERROR: begin
                pipe_hold   = 1'b1;
                mem_timeout = 1'b1;
            end
            default: begin
                state_d = RUN;
                timer_d = '0;
            end
        endcase
        // Controls are forced quiet for the whole reset assertion.
        if (arst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            pipe_hold    = 1'b0;
            mem_timeout  = 1'b0;
        end
    end

`ifdef PIPE_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters; cycles already in ERROR are not stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (state_q != ERROR) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (if_id_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
